// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Word alignment is tested with ALIGN_MASK against the low address bits.
package data_mem_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    function automatic logic is_aligned(input logic [1:0] addr_lo);
        return (addr_lo & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the port that was not granted last wins.
// last_i holds the index of the most recently served port.
module rr_arb2
    import data_mem_arbiter_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    // One-hot grant selection
    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates two requesters onto a single data memory with combinational read.
// Each transaction runs IDLE (grant) -> ACCESS (memory cycle) -> RESP (strobe).
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              port_q, port_d;
    logic              last_q, last_d;

    logic [1:0]        valid_s;
    logic [1:0]        grant_s;
    logic              hs_s;
    logic              aligned_s;

    assign valid_s   = {req1_valid, req0_valid};
    assign aligned_s = is_aligned(addr_q[1:0]);
    // Gating with rst keeps ready low while reset is held, even though state is IDLE.
    assign hs_s      = (state_q == ST_IDLE) && rst && (grant_s != 2'b00);

    rr_arb2 u_rr_arb2 (
        .valid_i (valid_s),
        .last_i  (last_q),
        .grant_o (grant_s)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            rdata_q <= {DATA_W{1'b0}};
            port_q  <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            port_q  <= port_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hs_s) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request latch, read capture and last-grant pointer next values
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        port_d  = port_q;
        last_d  = last_q;
        if (hs_s) begin
            we_d    = grant_s[1] ? req1_we    : req0_we;
            addr_d  = grant_s[1] ? req1_addr  : req0_addr;
            wdata_d = grant_s[1] ? req1_wdata : req0_wdata;
            port_d  = grant_s[1];
        end else begin
            port_d  = port_q;
        end
        // Writes and misaligned accesses return zero data.
        if (state_q == ST_ACCESS) begin
            rdata_d = (!we_q && aligned_s) ? mem_rd : {DATA_W{1'b0}};
        end else begin
            rdata_d = rdata_q;
        end
        if (state_q == ST_RESP) begin
            last_d = port_q;
        end else begin
            last_d = last_q;
        end
    end

    // Output decode
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        mem_we     = 1'b0;
        mem_a      = {ADDR_W{1'b0}};
        mem_wd     = {DATA_W{1'b0}};
        rsp0_valid = 1'b0;
        rsp0_rdata = {DATA_W{1'b0}};
        rsp0_err   = 1'b0;
        rsp1_valid = 1'b0;
        rsp1_rdata = {DATA_W{1'b0}};
        rsp1_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hs_s) begin
                    req0_ready = grant_s[0];
                    req1_ready = grant_s[1];
                end else begin
                    req0_ready = 1'b0;
                    req1_ready = 1'b0;
                end
            end
            ST_ACCESS: begin
                mem_we = we_q && aligned_s;
                mem_a  = addr_q;
                mem_wd = wdata_q;
            end
            ST_RESP: begin
                if (port_q) begin
                    rsp1_valid = 1'b1;
                    rsp1_rdata = rdata_q;
                    rsp1_err   = !aligned_s;
                end else begin
                    rsp0_valid = 1'b1;
                    rsp0_rdata = rdata_q;
                    rsp0_err   = !aligned_s;
                end
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench: a reference memory model predicts each response when the
// handshake is seen; responses are popped from the scoreboard and compared.
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req0_we;
    logic [31:0] req0_addr, req0_wdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [31:0] req1_addr, req1_wdata;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          gl_port[$];
    int          gl_cyc[$];
    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic [31:0] last_wr_addr;
    int          wr_count;
    int          cyc;
    int          viol;
    int          total;
    int          bad;
    bit          sb_en;
    int          rel_cyc;
    int          w0;

    data_mem_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp0_err   (rsp0_err),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .rsp1_err   (rsp1_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory with combinational read and synchronous write
    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            mem[mem_a[7:2]] <= mem_wd;
            last_wr_addr    <= mem_a;
            wr_count        <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        logic al;
        al      = (addr[1:0] == 2'b00);
        e.port  = p;
        e.err   = !al;
        e.cyc   = cyc;
        e.rdata = 32'h0;
        if (we && al) ref_mem[addr[7:2]] = wd;
        if (!we && al) e.rdata = ref_mem[addr[7:2]];
        sb.push_back(e);
        gl_port.push_back(p);
        gl_cyc.push_back(cyc);
    endtask

    // Handshake capture and response checking
    always @(negedge clk) begin
        exp_t e;
        if (rst && sb_en) begin
            if (req0_valid && req0_ready) push(0, req0_we, req0_addr, req0_wdata);
            if (req1_valid && req1_ready) push(1, req1_we, req1_addr, req1_wdata);
        end
        if (req0_ready && req1_ready) viol++;
        if (rsp0_valid && rsp1_valid) viol++;
        if (!rsp0_valid && (rsp0_rdata != 32'h0 || rsp0_err)) viol++;
        if (!rsp1_valid && (rsp1_rdata != 32'h0 || rsp1_err)) viol++;
        if (rsp0_valid || rsp1_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp1_valid), 32'(rsp0_valid));
            end else begin
                e = sb.pop_front();
                chk("rsp_port", 32'(rsp1_valid), 32'(e.port));
                chk("rsp_rdata", rsp1_valid ? rsp1_rdata : rsp0_rdata, e.rdata);
                chk("rsp_err", 32'(rsp1_valid ? rsp1_err : rsp0_err), 32'(e.err));
                chk("rsp_latency", 32'(cyc - e.cyc), 32'd2);
            end
        end
    end

    task automatic drive(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        int  n;
        logic rdy;
        if (p == 0) begin
            req0_we = we; req0_addr = addr; req0_wdata = wd; req0_valid = 1'b1;
        end else begin
            req1_we = we; req1_addr = addr; req1_wdata = wd; req1_valid = 1'b1;
        end
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 60) begin
            @(negedge clk);
            rdy = (p == 0) ? req0_ready : req1_ready;
            n++;
        end
        chk("grant_wait", 32'(rdy), 32'd1);
        @(posedge clk);
        #1;
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; sb_en = 1'b1;
        cyc = 0; viol = 0; total = 0; bad = 0; wr_count = 0; last_wr_addr = 32'h0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 32'h0; req0_wdata = 32'h0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 32'h0; req1_wdata = 32'h0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end

        // Reset state, then tie right after reset release
        fork
            drive(0, 1'b1, 32'h50, 32'hCAFEBABE);
            drive(1, 1'b0, 32'h50, 32'h0);
            begin
                @(negedge clk);
                chk("rst_ready0", 32'(req0_ready), 32'd0);
                chk("rst_ready1", 32'(req1_ready), 32'd0);
                chk("rst_mem_we", 32'(mem_we), 32'd0);
                chk("rst_mem_a", mem_a, 32'h0);
                chk("rst_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
                @(posedge clk);
                #1;
                rst = 1'b1;
                rel_cyc = cyc;
            end
        join
        drain();
        chk("first_grant_cyc", 32'(gl_cyc[0]), 32'(rel_cyc));
        chk("first_grant_port", 32'(gl_port[0]), 32'd0);
        chk("second_grant_port", 32'(gl_port[1]), 32'd1);

        // Aligned write then read back on port 0
        w0 = wr_count;
        drive(0, 1'b1, 32'h28, 32'hDEADBEEF);
        drain();
        chk("wr_once", 32'(wr_count - w0), 32'd1);
        chk("wr_addr", last_wr_addr, 32'h28);
        chk("mem_28", mem[10], 32'hDEADBEEF);
        drive(0, 1'b0, 32'h28, 32'h0);
        drain();

        // Misaligned write on port 1 must not touch memory
        w0 = wr_count;
        drive(1, 1'b1, 32'h2A, 32'h12345678);
        drain();
        chk("misal_no_wr", 32'(wr_count - w0), 32'd0);
        chk("misal_mem_28", mem[10], 32'hDEADBEEF);

        // Both ports held valid: grants alternate with 3-cycle spacing
        gl_port.delete();
        gl_cyc.delete();
        fork
            begin
                drive(0, 1'b1, 32'h30, 32'hA0A0A0A0);
                drive(0, 1'b1, 32'h34, 32'hB1B1B1B1);
                drive(0, 1'b1, 32'h3C, 32'hC2C2C2C2);
            end
            begin
                drive(1, 1'b0, 32'h30, 32'h0);
                drive(1, 1'b0, 32'h34, 32'h0);
                drive(1, 1'b0, 32'h3C, 32'h0);
            end
        join
        drain();
        chk("rr_count", 32'(gl_port.size()), 32'd6);
        for (int i = 0; i < 6 && i < gl_port.size(); i++) begin
            chk("rr_order", 32'(gl_port[i]), 32'(i % 2));
            if (i > 0) chk("rr_spacing", 32'(gl_cyc[i] - gl_cyc[i-1]), 32'd3);
        end

        // Reset during ACCESS of a write aborts it
        sb_en = 1'b0;
        w0 = wr_count;
        req0_we = 1'b1; req0_addr = 32'h3C; req0_wdata = 32'hBAD0BAD0; req0_valid = 1'b1;
        @(negedge clk);
        chk("abort_grant", 32'(req0_ready), 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_mem_a", mem_a, 32'h0);
        chk("abort_mem_wd", mem_wd, 32'h0);
        chk("abort_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        sb_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_wr", 32'(wr_count - w0), 32'd0);
        chk("abort_mem_3c", mem[15], 32'hC2C2C2C2);
        drive(0, 1'b0, 32'h3C, 32'h0);
        drain();

        chk("protocol_viol", 32'(viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
